// File: rtl/jk_flip_flop.sv
// rtl/jk_flip_flop.sv - parameterised bank of positive-edge JK flip-flops
//
// Purpose: WIDTH independent JK flops with complementary outputs.
//          Asynchronous active-low reset loads RESET_VALUE.
// Ports:
//   clk  in   clock, state changes on rising edge (except reset)
//   rst  in   asynchronous active-low reset
//   j    in   [WIDTH] per-bit set input
//   k    in   [WIDTH] per-bit clear input
//   q    out  [WIDTH] registered state
//   qb   out  [WIDTH] combinational complement of q
module jk_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Characteristic equation q+ = j&~q | ~k&q covers hold/clear/set/toggle
  // per bit with no interaction between bits.
  always_comb begin
    q_d = (j & ~q_q) | (~k & q_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  // Taken from the register itself so q and qb can never disagree.
  assign qb = ~q_q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// tb/tb_jk_flip_flop.sv - directed self-checking bench for jk_flip_flop
module tb_jk_flip_flop;

  logic       clk;
  logic       rst1;
  logic [0:0] j1, k1, q1, qb1;
  logic       rst4;
  logic [3:0] j4, k4, q4, qb4;

  int total = 0;
  int bad   = 0;

  jk_flip_flop u_dut1 (
    .clk (clk),
    .rst (rst1),
    .j   (j1),
    .k   (k1),
    .q   (q1),
    .qb  (qb1)
  );

  jk_flip_flop #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .j   (j4),
    .k   (k4),
    .q   (q4),
    .qb  (qb4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive1(input string tag, input logic jv, input logic kv, input logic exp);
    @(negedge clk);
    j1 = jv;
    k1 = kv;
    @(posedge clk);
    #1;
    check(tag, {63'd0, q1}, {63'd0, exp});
    check({tag, "_qb"}, {63'd0, qb1}, {63'd0, ~exp});
  endtask

  task automatic drive4(input string tag, input logic [3:0] jv, input logic [3:0] kv,
                        input logic [3:0] exp);
    @(negedge clk);
    j4 = jv;
    k4 = kv;
    @(posedge clk);
    #1;
    check(tag, {60'd0, q4}, {60'd0, exp});
    check({tag, "_qb"}, {60'd0, qb4}, {60'd0, ~exp});
  endtask

  initial begin
    rst1 = 1'b1;
    rst4 = 1'b1;
    j1   = 1'b1;
    k1   = 1'b1;
    j4   = 4'hf;
    k4   = 4'hf;
    #1;
    rst1 = 1'b0;
    rst4 = 1'b0;
    #1;
    check("rst_async_q1",  {63'd0, q1},  64'd0);
    check("rst_async_qb1", {63'd0, qb1}, 64'd1);
    check("rst_async_q4",  {60'd0, q4},  64'ha);
    check("rst_async_qb4", {60'd0, qb4}, 64'h5);

    // Edges at 10 and 30 ns with toggle inputs must not disturb reset.
    for (int e = 0; e < 2; e++) begin
      @(posedge clk);
      #1;
      check("rst_edge_q1",  {63'd0, q1},  64'd0);
      check("rst_edge_qb1", {63'd0, qb1}, 64'd1);
      check("rst_edge_q4",  {60'd0, q4},  64'ha);
    end

    #4;
    rst1 = 1'b1;
    rst4 = 1'b1;
    j1   = 1'b0;
    k1   = 1'b0;
    j4   = 4'h0;
    k4   = 4'h0;
    #1;
    check("release_q1", {63'd0, q1}, 64'd0);
    check("release_q4", {60'd0, q4}, 64'ha);

    drive1("jk00", 1'b0, 1'b0, 1'b0);
    drive1("jk01", 1'b0, 1'b1, 1'b0);
    drive1("jk10", 1'b1, 1'b0, 1'b1);
    drive1("jk11", 1'b1, 1'b1, 1'b0);

    drive1("set",     1'b1, 1'b0, 1'b1);
    drive1("hold",    1'b0, 1'b0, 1'b1);
    drive1("toggle1", 1'b1, 1'b1, 1'b0);
    drive1("toggle2", 1'b1, 1'b1, 1'b1);
    drive1("toggle3", 1'b1, 1'b1, 1'b0);
    drive1("set2",    1'b1, 1'b0, 1'b1);

    // Mid-cycle reset while q=1 and toggling.
    @(negedge clk);
    j1 = 1'b1;
    k1 = 1'b1;
    #3;
    rst1 = 1'b0;
    #1;
    check("midrst_q1",  {63'd0, q1},  64'd0);
    check("midrst_qb1", {63'd0, qb1}, 64'd1);
    @(posedge clk);
    #1;
    check("midrst_edge_q1", {63'd0, q1}, 64'd0);
    @(negedge clk);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_toggle", {63'd0, q1},  64'd1);
    check("post_rst_qb",     {63'd0, qb1}, 64'd0);

    // A j pulse that ends before the edge must not be seen.
    drive1("clear", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    j1 = 1'b0;
    k1 = 1'b0;
    #2;
    j1 = 1'b1;
    #3;
    j1 = 1'b0;
    @(posedge clk);
    #1;
    check("glitch_q1", {63'd0, q1}, 64'd0);

    check("w4_idle_hold", {60'd0, q4}, 64'ha);
    drive4("w4_setclr", 4'b0101, 4'b1010, 4'b0101);
    drive4("w4_toggle", 4'b1111, 4'b1111, 4'b1010);
    drive4("w4_mixed",  4'b0011, 4'b0110, 4'b1001);
    drive4("w4_hold",   4'b0000, 4'b0000, 4'b1001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jk_flip_flop.md
Name: jk_flip_flop

Overview:
- Parameterised bank of positive-edge-triggered JK flip-flops with complementary outputs.
- Each bit updates independently on the rising clock edge per the standard JK truth table.
- General-purpose sequential primitive for counters, toggle registers and control latches; default configuration is a single flop.

Parameters:
- WIDTH, 1, number of independent JK flops (bits); legal range 1..64.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q while reset is asserted.

Ports:
- clk  input  1  clock; all state changes on the rising edge, except reset.
- rst  input  1  asynchronous active-low reset. 0 = reset asserted, 1 = normal operation.
- j  input  WIDTH  per-bit J (set) input.
- k  input  WIDTH  per-bit K (reset) input.
- q  output  WIDTH  registered flop state.
- qb  output  WIDTH  complement of q.

Behaviour:
- Reset:
  - rst=0 forces q=RESET_VALUE and qb=~RESET_VALUE immediately, without waiting for a clock edge.
  - Reset dominates every clock edge that occurs while rst=0; j and k are ignored.
- Reset release:
  - rst rising 0->1 causes no state change by itself.
  - The first rising clk edge with rst=1 applies the JK rule to the RESET_VALUE state.
- Clocked update (rst=1), rising edge of clk, evaluated per bit i using j[i],k[i] sampled at the edge:
  - 00: hold, q[i] unchanged.
  - 01: clear, q[i]=0.
  - 10: set, q[i]=1.
  - 11: toggle, q[i]=~q[i].
- Latency: one clock. Changes on j/k between edges have no effect on q.
- qb:
  - Always the bitwise complement of q, including during and immediately after reset.
  - Derived combinationally from the q register; never a separately clocked register.
  - q and qb are never equal on any bit.
- Bits are fully independent: no carry or interaction between bits.
- Falling clock edge: no effect.
- X/Z on j or k at a clocked edge:
  - Simulation may propagate X to q.
  - Synthesis makes no special-case handling.
- Initial state before the first reset is undefined. Integrators must assert rst at power-up.

Test Plan:
- Power-up reset (clk period 20 ns, rst=0 for 30 ns, j=k=1 during reset) -> q=0, qb=1 throughout, despite clock edges and toggle inputs.
- After rst=1, apply j,k=00 then 01 then 10 then 11, each held 20 ns (one edge) -> q = 0, 0, 1, 0 and qb = 1, 1, 0, 1 after each respective edge.
- From q=0: j,k=10 -> q=1. Then 00 -> q stays 1. Then 11 for three edges -> q = 0, 1, 0.
- Assert rst=0 mid-cycle while q=1 and j,k=11 -> q=0 and qb=1 immediately, before the next edge. Deassert rst -> the next edge toggles q to 1.
- WIDTH=4, RESET_VALUE=4'b1010:
  - During reset -> q=1010, qb=0101.
  - Then j=0101, k=1010 -> q=0101.
  - Then j=k=1111 -> q=1010.
- Glitch j between edges (pulse j=1 for 3 ns while k=0, low again before the edge) -> q unchanged at the next edge.
